axis_sample_fifo: RTL and testbench
===================================

Name: axis_sample_fifo

Overview:
- Synchronous AXI4-Stream FIFO placed directly upstream of the AXI4-Lite stream reader.
- Buffers 32-bit sample words from a DSP/sample source so the processor-side DMA can drain them in bursts.
- Provides occupancy count, a threshold "data ready" flag for DMA triggering, a sticky overflow flag and a synchronous flush.

Parameters:
- DATA_WIDTH, 32, stream word width.
- DEPTH_LOG2, 10, log2 of memory storage words (memory depth = 2^DEPTH_LOG2).

Ports:
- aclk  input  1  clock.
- aresetn  input  1  synchronous active-low reset.
- s_axis_tdata  input  DATA_WIDTH  upstream sample data.
- s_axis_tvalid  input  1  upstream data valid.
- s_axis_tready  output  1  FIFO can accept a word.
- m_axis_tdata  output  DATA_WIDTH  data to stream reader.
- m_axis_tvalid  output  1  output word valid.
- m_axis_tready  input  1  stream reader accepts word.
- flush  input  1  synchronous flush, active high.
- threshold  input  DEPTH_LOG2+1  data-ready level in words.
- count  output  DEPTH_LOG2+1  words held (memory plus output register).
- data_ready  output  1  registered, count >= threshold.
- overflow  output  1  sticky: write attempted while full.
- clear_overflow  input  1  clears overflow.

Behaviour:
- Reset is synchronous on aresetn=0 at the aclk edge:
  - Pointers and count go to 0.
  - m_axis_tvalid=0, m_axis_tdata=0.
  - s_axis_tready=1, data_ready=0, overflow=0.
- Structure: dual-port memory array (registered read) plus a one-word output register, first-word-fall-through.
- Write handshake:
  - A word is accepted when s_axis_tvalid & s_axis_tready.
  - s_axis_tready is registered; it is 1 when memory occupancy < 2^DEPTH_LOG2, and also accounts for a same-cycle write.
  - tready never depends combinationally on tvalid.
- Read handshake:
  - A transfer occurs when m_axis_tvalid & m_axis_tready.
  - m_axis_tdata is held stable while m_axis_tvalid=1 and m_axis_tready=0.
  - The output register refills from memory whenever it is empty, or is being consumed this cycle, and memory is non-empty.
- Latency: a word written into an empty FIFO at edge N is on m_axis_tvalid/tdata after edge N+2. Back-to-back reads sustain 1 word/cycle.
- count:
  - +1 on an accepted write, -1 on an output transfer, unchanged when both occur in the same cycle.
  - Maximum value is 2^DEPTH_LOG2+1.
  - Updates one cycle after the handshake edge.
- data_ready: registered compare of the updated count against threshold. threshold=0 forces data_ready=1 out of reset+1 cycle.
- Pointers are DEPTH_LOG2 bits and wrap modulo 2^DEPTH_LOG2 with no gap or duplicated word across the wrap.
- overflow:
  - Set on any cycle with s_axis_tvalid=1 & s_axis_tready=0.
  - Cleared by clear_overflow=1. If clear and a new overflow event coincide, set wins.
  - Not affected by flush.
- flush=1 at an edge: pointers and count go to 0, m_axis_tvalid=0, s_axis_tready=1.
  - Any same-cycle write is discarded.
  - A same-cycle output handshake is treated as complete (the word is gone).
  - flush has priority over all traffic.
- Simultaneous read and write when full: the write is refused (tready=0 was registered). The read proceeds and tready returns to 1 the next cycle.
- Empty FIFO: m_axis_tvalid=0, m_axis_tready is ignored, count stays 0 with no underflow.
- Reset mid-transfer: all state clears as at reset; partial data is lost with no spurious valid.

Test Plan (bench uses DEPTH_LOG2=4, capacity 17 words):
- Reset, then write 0x0000_0001 once with m_axis_tready=0 -> m_axis_tvalid=1 two cycles later, tdata=0x1, count=1. With threshold=1, data_ready=1.
- Write 0x100..0x110 (17 words) with m_axis_tready=0 -> s_axis_tready=0 after the 17th word, count=17. Holding tvalid one more cycle sets overflow=1. Draining yields 0x100..0x110 in order with nothing lost.
- Continuous write and continuous read of 40 incrementing words with m_axis_tready toggling 1,0,1,0 -> output sequence is exact across pointer wrap, with no duplicates or drops.
- Hold full at 17 words and assert m_axis_tready and s_axis_tvalid in the same cycle -> the read transfers, the write is refused, count=16, then s_axis_tready=1.
- After 5 words are buffered, pulse flush for 1 cycle -> count=0, m_axis_tvalid=0, overflow unchanged. The next written word 0xABCD appears after 2 cycles.
- With overflow=1, pulse clear_overflow while no write is pending -> overflow=0. Repeat with a simultaneous refused write -> overflow stays 1.

Source files
------------

// File: rtl/axis_sample_fifo.sv
// AXI4-Stream sample FIFO with first-word-fall-through output register, occupancy
// count, threshold data-ready flag, sticky overflow and synchronous flush.
module axis_sample_fifo #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    input  logic                  flush,
    input  logic [DEPTH_LOG2:0]   threshold,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  data_ready,
    output logic                  overflow,
    input  logic                  clear_overflow
);

    localparam int unsigned DEPTH = 32'd1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         mem_cnt_q, mem_cnt_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  wr_pend_q, wr_pend_d;
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q;
    logic                  tready_q, tready_d;
    logic                  data_ready_q, data_ready_d;
    logic                  overflow_q, overflow_d;

    logic wr_fire_c;
    logic rd_fire_c;
    logic rd_avail_c;
    logic load_c;
    logic mem_we_c;

    // The newest written word becomes readable one cycle after it lands, like a
    // registered-read RAM; this gives the two-edge write-to-output latency.
    always_comb begin
        wr_fire_c  = s_axis_tvalid & tready_q;
        rd_fire_c  = out_valid_q & m_axis_tready;
        rd_avail_c = mem_cnt_q > CW'(wr_pend_q);
        load_c     = rd_avail_c & (~out_valid_q | rd_fire_c) & ~flush;
        mem_we_c   = wr_fire_c & ~flush & aresetn;
    end

    // Next-state logic; flush overrides all traffic but leaves overflow alone.
    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        mem_cnt_d   = mem_cnt_q;
        count_d     = count_q;
        wr_pend_d   = 1'b0;
        out_valid_d = out_valid_q;
        tready_d    = tready_q;
        overflow_d  = overflow_q;

        if (flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            mem_cnt_d   = '0;
            count_d     = '0;
            out_valid_d = 1'b0;
            tready_d    = 1'b1;
        end else begin
            if (wr_fire_c) begin
                wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
            end
            if (load_c) begin
                rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
            end
            wr_pend_d   = wr_fire_c;
            mem_cnt_d   = mem_cnt_q + CW'(wr_fire_c) - CW'(load_c);
            count_d     = count_q + CW'(wr_fire_c) - CW'(rd_fire_c);
            out_valid_d = load_c | (out_valid_q & ~rd_fire_c);
            tready_d    = mem_cnt_d < CW'(DEPTH);
        end

        data_ready_d = count_d >= threshold;

        if (s_axis_tvalid & ~tready_q) begin
            overflow_d = 1'b1;
        end else if (clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_cnt_q    <= '0;
            count_q      <= '0;
            wr_pend_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            tready_q     <= 1'b1;
            data_ready_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_cnt_q    <= mem_cnt_d;
            count_q      <= count_d;
            wr_pend_q    <= wr_pend_d;
            out_valid_q  <= out_valid_d;
            tready_q     <= tready_d;
            data_ready_q <= data_ready_d;
            overflow_q   <= overflow_d;
            if (load_c) begin
                out_data_q <= mem_q[rd_ptr_q];
            end
        end
    end

    // Storage array, no reset.
    always_ff @(posedge aclk) begin
        if (mem_we_c) begin
            mem_q[wr_ptr_q] <= s_axis_tdata;
        end
    end

    assign s_axis_tready = tready_q;
    assign m_axis_tdata  = out_data_q;
    assign m_axis_tvalid = out_valid_q;
    assign count         = count_q;
    assign data_ready    = data_ready_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_axis_sample_fifo.sv
// Directed self-checking bench for axis_sample_fifo with DEPTH_LOG2=4 (17 words).
module tb_axis_sample_fifo;

    localparam int unsigned DW = 32;
    localparam int unsigned DL = 4;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [DW-1:0] s_axis_tdata;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          flush;
    logic [DL:0]   threshold;
    logic [DL:0]   count;
    logic          data_ready;
    logic          overflow;
    logic          clear_overflow;

    int errors = 0;
    int checks = 0;

    always #5 aclk = ~aclk;

    axis_sample_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
        .aclk          (aclk),
        .aresetn       (aresetn),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .flush         (flush),
        .threshold     (threshold),
        .count         (count),
        .data_ready    (data_ready),
        .overflow      (overflow),
        .clear_overflow(clear_overflow)
    );

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic test_reset();
        aresetn = 1'b0; s_axis_tvalid = 1'b0; s_axis_tdata = '0; m_axis_tready = 1'b0;
        flush = 1'b0; threshold = '0; clear_overflow = 1'b0;
        tick(); tick();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %0b expected 0", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== 32'h0) begin errors++; $display("FAIL reset_tdata: got %h expected 0", m_axis_tdata); end
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %0b expected 1", s_axis_tready); end
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL reset_data_ready: got %0b expected 0", data_ready); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %0b expected 0", overflow); end
        aresetn = 1'b1;
        tick();
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL thresh0_data_ready: got %0b expected 1", data_ready); end
        threshold = 5'd1;
        tick();
        checks++; if (data_ready !== 1'b0) begin errors++; $display("FAIL thresh1_empty_data_ready: got %0b expected 0", data_ready); end
    endtask

    task automatic test_single_write();
        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'h0000_0001;
        tick();
        s_axis_tvalid = 1'b0;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL single_lat1: got %0b expected 0", m_axis_tvalid); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count_early: got %0d expected 1", count); end
        tick();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL single_lat2: got %0b expected 0", m_axis_tvalid); end
        tick();
        checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("FAIL single_tvalid: got %0b expected 1", m_axis_tvalid); end
        checks++; if (m_axis_tdata !== 32'h1) begin errors++; $display("FAIL single_tdata: got %h expected 1", m_axis_tdata); end
        checks++; if (count !== 5'd1) begin errors++; $display("FAIL single_count: got %0d expected 1", count); end
        checks++; if (data_ready !== 1'b1) begin errors++; $display("FAIL single_data_ready: got %0b expected 1", data_ready); end
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
        checks++; if (m_axis_tvalid !== 1'b0 || count !== 5'd0) begin
            errors++; $display("FAIL single_drain: got tvalid=%0b count=%0d expected 0/0", m_axis_tvalid, count);
        end
    endtask

    task automatic test_fill_overflow();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = 32'h100 + 32'(i);
            checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL fill_tready[%0d]: got %0b expected 1", i, s_axis_tready); end
            tick();
        end
        s_axis_tdata = 32'h111;
        checks++; if (s_axis_tready !== 1'b0) begin errors++; $display("FAIL full_tready: got %0b expected 0", s_axis_tready); end
        checks++; if (count !== 5'd17) begin errors++; $display("FAIL full_count: got %0d expected 17", count); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_no_overflow_yet: got %0b expected 0", overflow); end
        tick();
        s_axis_tvalid = 1'b0;
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %0b expected 1", overflow); end
        checks++; if (count !== 5'd17) begin errors++; $display("FAIL overflow_count: got %0d expected 17", count); end
        m_axis_tready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h100 + 32'(i)) begin
                errors++; $display("FAIL fill_drain[%0d]: got v=%0b d=%h expected 1/%h", i, m_axis_tvalid, m_axis_tdata, 32'h100 + 32'(i));
            end
            tick();
        end
        m_axis_tready = 1'b0;
        checks++; if (m_axis_tvalid !== 1'b0 || count !== 5'd0) begin
            errors++; $display("FAIL fill_empty: got tvalid=%0b count=%0d expected 0/0", m_axis_tvalid, count);
        end
    endtask

    task automatic test_stream_wrap();
        int wr_idx = 0;
        int rd_idx = 0;
        int cyc    = 0;
        while (rd_idx < 40 && cyc < 400) begin
            m_axis_tready = ((cyc % 2) == 0);
            s_axis_tvalid = (wr_idx < 40);
            s_axis_tdata  = 32'h300 + 32'(wr_idx);
            if (m_axis_tvalid === 1'b1 && m_axis_tready) begin
                checks++; if (m_axis_tdata !== 32'h300 + 32'(rd_idx)) begin
                    errors++; $display("FAIL wrap_data[%0d]: got %h expected %h", rd_idx, m_axis_tdata, 32'h300 + 32'(rd_idx));
                end
                rd_idx++;
            end
            if (s_axis_tvalid && s_axis_tready === 1'b1) wr_idx++;
            tick();
            cyc++;
        end
        s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        checks++; if (rd_idx != 40) begin errors++; $display("FAIL wrap_timeout: got %0d words expected 40", rd_idx); end
        checks++; if (m_axis_tvalid !== 1'b0 || count !== 5'd0) begin
            errors++; $display("FAIL wrap_empty: got tvalid=%0b count=%0d expected 0/0", m_axis_tvalid, count);
        end
    endtask

    task automatic test_full_rw();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = 32'h200 + 32'(i);
            tick();
        end
        s_axis_tvalid = 1'b0;
        checks++; if (count !== 5'd17 || s_axis_tready !== 1'b0) begin
            errors++; $display("FAIL rw_full: got count=%0d tready=%0b expected 17/0", count, s_axis_tready);
        end
        m_axis_tready = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 32'h2FF;
        tick();
        s_axis_tvalid = 1'b0; m_axis_tready = 1'b0;
        checks++; if (count !== 5'd16) begin errors++; $display("FAIL rw_count: got %0d expected 16", count); end
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL rw_tready: got %0b expected 1", s_axis_tready); end
        m_axis_tready = 1'b1;
        for (int i = 1; i < 17; i++) begin
            checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'h200 + 32'(i)) begin
                errors++; $display("FAIL rw_drain[%0d]: got v=%0b d=%h expected 1/%h", i, m_axis_tvalid, m_axis_tdata, 32'h200 + 32'(i));
            end
            tick();
        end
        m_axis_tready = 1'b0;
        checks++; if (m_axis_tvalid !== 1'b0 || count !== 5'd0) begin
            errors++; $display("FAIL rw_empty: got tvalid=%0b count=%0d expected 0/0", m_axis_tvalid, count);
        end
    endtask

    task automatic test_flush();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = 32'h400 + 32'(i);
            tick();
        end
        s_axis_tvalid = 1'b0;
        tick(); tick();
        checks++; if (count !== 5'd5 || m_axis_tdata !== 32'h400) begin
            errors++; $display("FAIL flush_pre: got count=%0d d=%h expected 5/400", count, m_axis_tdata);
        end
        flush = 1'b1; s_axis_tvalid = 1'b1; s_axis_tdata = 32'hDEAD;
        tick();
        flush = 1'b0; s_axis_tvalid = 1'b0;
        checks++; if (count !== 5'd0) begin errors++; $display("FAIL flush_count: got %0d expected 0", count); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL flush_tvalid: got %0b expected 0", m_axis_tvalid); end
        checks++; if (s_axis_tready !== 1'b1) begin errors++; $display("FAIL flush_tready: got %0b expected 1", s_axis_tready); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL flush_overflow: got %0b expected 1", overflow); end
        tick(); tick();
        checks++; if (m_axis_tvalid !== 1'b0 || count !== 5'd0) begin
            errors++; $display("FAIL flush_discard: got tvalid=%0b count=%0d expected 0/0", m_axis_tvalid, count);
        end
        s_axis_tvalid = 1'b1; s_axis_tdata = 32'hABCD;
        tick();
        s_axis_tvalid = 1'b0;
        tick();
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("FAIL post_flush_lat: got %0b expected 0", m_axis_tvalid); end
        tick();
        checks++; if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== 32'hABCD || count !== 5'd1) begin
            errors++; $display("FAIL post_flush_word: got v=%0b d=%h count=%0d expected 1/abcd/1", m_axis_tvalid, m_axis_tdata, count);
        end
        m_axis_tready = 1'b1;
        tick();
        m_axis_tready = 1'b0;
    endtask

    task automatic test_overflow_clear();
        m_axis_tready = 1'b0;
        clear_overflow = 1'b1;
        tick();
        clear_overflow = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %0b expected 0", overflow); end
        for (int i = 0; i < 17; i++) begin
            s_axis_tvalid = 1'b1; s_axis_tdata = 32'h500 + 32'(i);
            tick();
        end
        s_axis_tdata = 32'h511;
        tick();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_reset: got %0b expected 1", overflow); end
        clear_overflow = 1'b1;
        tick();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set_wins: got %0b expected 1", overflow); end
        s_axis_tvalid = 1'b0;
        tick();
        clear_overflow = 1'b0;
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear2: got %0b expected 0", overflow); end
    endtask

    task automatic test_reset_midstream();
        m_axis_tready = 1'b1;
        aresetn = 1'b0;
        tick();
        aresetn = 1'b1; m_axis_tready = 1'b0;
        checks++; if (count !== 5'd0 || m_axis_tvalid !== 1'b0 || m_axis_tdata !== 32'h0 || s_axis_tready !== 1'b1) begin
            errors++; $display("FAIL midreset_state: got count=%0d v=%0b d=%h tready=%0b expected 0/0/0/1",
                               count, m_axis_tvalid, m_axis_tdata, s_axis_tready);
        end
        tick(); tick(); tick();
        checks++; if (m_axis_tvalid !== 1'b0 || count !== 5'd0) begin
            errors++; $display("FAIL midreset_idle: got tvalid=%0b count=%0d expected 0/0", m_axis_tvalid, count);
        end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_fill_overflow();
        test_stream_wrap();
        test_full_rw();
        test_flush();
        test_overflow_clear();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
